// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit driving a byte-addressed data memory for one cycle per access
module lsu_mem_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic [1:0]        resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic [2:0]        mem_write_enable,
    output logic              mem_read_enable,
    input  logic [31:0]       mem_data_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_W:0] MEM_LAST = (ADDR_W+1)'(MEM_BYTES - 1);

    state_t            state, state_nxt;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       rdata_q;
    logic [1:0]        err_q;
    logic [1:0]        req_err;
    logic [2:0]        size_m1;
    logic [ADDR_W:0]   last_byte;
    logic [31:0]       sw;
    logic [31:0]       load_ext;

    // One extra bit on the last-byte sum so an address near the top cannot wrap into range.
    always_comb begin : decode
        size_m1 = 3'd0;
        case (req_funct3[1:0])
            2'b01:   size_m1 = 3'd1;
            2'b10:   size_m1 = 3'd3;
            default: size_m1 = 3'd0;
        endcase
        last_byte = {1'b0, req_addr} + (ADDR_W+1)'(size_m1);
        req_err   = 2'b00;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]))
            req_err = 2'b11;
        else if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
            req_err = 2'b01;
        else if (last_byte > MEM_LAST)
            req_err = 2'b10;
    end

    always_comb begin : fsm_next
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = (req_err == 2'b00) ? ACCESS : RESP;
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Memory strobes are gated by rst so a reset landing in ACCESS drops the pending write.
    always_comb begin : mem_drive
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 3'b000;
        mem_read_enable  = 1'b0;
        if (rst && state == ACCESS) begin
            mem_address = r_addr;
            if (r_we) begin
                mem_write_data = r_wdata;
                case (r_funct3[1:0])
                    2'b00:   mem_write_enable = 3'b001;
                    2'b01:   mem_write_enable = 3'b011;
                    default: mem_write_enable = 3'b111;
                endcase
            end else begin
                mem_read_enable = 1'b1;
            end
        end
    end

    assign sw = {mem_data_out[7:0], mem_data_out[15:8], mem_data_out[23:16], mem_data_out[31:24]};

    always_comb begin : extend
        case (r_funct3)
            3'b000:  load_ext = {{24{sw[7]}}, sw[7:0]};
            3'b100:  load_ext = {24'd0, sw[7:0]};
            3'b001:  load_ext = {{16{sw[15]}}, sw[15:0]};
            3'b101:  load_ext = {16'd0, sw[15:0]};
            default: load_ext = sw;
        endcase
    end

    always_ff @(posedge clk) begin : datapath
        if (!rst) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        err_q    <= req_err;
                        rdata_q  <= 32'd0;
                    end
                end
                ACCESS: rdata_q <= r_we ? 32'd0 : load_ext;
                RESP: begin
                    if (resp_ready) begin
                        rdata_q <= 32'd0;
                        err_q   <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting directly upstream of the byte-addressed data memory.
- Accepts one load or store request per transaction over a valid/ready handshake and decodes RISC-V funct3 into the memory's byte/half/word write-enable code.
- Drives the memory for exactly one cycle, then byte-orders and sign/zero-extends load data.
- Reports misaligned, out-of-range and illegal-size accesses without touching memory.

Parameters:
- ADDR_W, 32, width of request and memory address.
- MEM_BYTES, 32, number of bytes in the attached memory; sets the range check.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, little-endian lanes.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_write_enable  out  3  001 byte, 011 half, 111 word, 000 none.
- mem_read_enable  out  1  to memory read_enable.
- mem_data_out  in  32  memory read data, combinational; byte at address is in [31:24].

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (rst=0 at a clock edge): state IDLE. resp_valid=0, resp_rdata=0, resp_err=00, all mem_* outputs 0, req_ready=1 on the following cycle.
- Reset mid-transaction aborts with no response. Any in-flight write that has not reached its edge is dropped.
- IDLE: req_ready=1. A handshake (req_valid & req_ready) at edge T registers we, funct3, addr and wdata, and computes err.
- Error checks, in priority order:
  - illegal: funct3 in {011, 110, 111}, or a store with funct3 100/101 → 11.
  - misaligned: half with addr[0]=1, or word with addr[1:0]≠0 → 01.
  - range: addr + size − 1 > MEM_BYTES − 1 → 10. The sum is computed at ADDR_W+1 bits so it cannot wrap.
- err≠00: go to RESP at T+1. No memory access at all; mem_write_enable stays 000.
- err=00: go to ACCESS at T+1.
- ACCESS lasts exactly one cycle:
  - mem_address = registered addr.
  - Store: mem_write_data = wdata; mem_write_enable = 001/011/111 for B/H/W. The write commits at the edge ending ACCESS.
  - Load: mem_read_enable=1. At the same edge, capture sw = {d[7:0], d[15:8], d[23:16], d[31:24]} from mem_data_out.
- Load extension from sw:
  - B: sign-extend sw[7:0].
  - BU: zero-extend sw[7:0].
  - H: sign-extend sw[15:0].
  - HU: zero-extend sw[15:0].
  - W: sw.
- Outside ACCESS, all mem_* outputs are 0.
- RESP: resp_valid=1. resp_rdata and resp_err stay stable until resp_ready=1 at an edge; then state IDLE, resp_valid=0.
- Latency: request edge T → resp_valid high from T+2 (ok) or T+1 (error). Throughput is at most one transaction per 3 cycles (2 on error).
- req_valid while not IDLE is ignored; the requester must hold its request.

Test Plan:
- SW addr 0x04 wdata 0x87654321, then LW 0x04 → write_enable 111 for one cycle; memory bytes 4..7 = 21,43,65,87; LW resp_rdata 0x87654321, err 00, resp_valid at T+2.
- After the above:
  - LB 0x04 → 0x00000021.
  - LB 0x07 → 0xFFFFFF87.
  - LBU 0x07 → 0x00000087.
  - LH 0x06 → 0xFFFF8765.
  - LHU 0x06 → 0x00008765.
- SH 0x10 wdata 0xAAAA1234 → write_enable 011; LW 0x10 → 0x00001234 (post-reset memory).
- Errors:
  - LW 0x02 → err 01.
  - LH 0x1F → err 01.
  - SB with funct3 100 → err 11.
  - LW 0x1E → err 01.
  - LB 0x20 → err 10.
  - LW 0x1C → err 00.
  - In every error case: resp at T+1, mem_write_enable never nonzero, rdata 0.
- Backpressure: hold resp_ready=0 for 5 cycles after an LW → resp_valid, rdata and err held constant, req_ready=0, a new req_valid is ignored; release → IDLE next cycle.
- Assert rst=0 during ACCESS of an SW → next cycle all outputs 0, state IDLE, no resp_valid; a subsequent LW of that address returns 0.
